// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, baud derivation, 8N1 frame shape.
// Reused by the receive path and any future transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   function automatic int unsigned clks_per_bit(
      input int unsigned clk_freq,
      input int unsigned baud
   );
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte-stream bundle: serial line in, byte/strobe and frame error out.
// master = receiver side, slave = line driver / byte consumer.
interface uart_rx_byte_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;

   modport master (
      input  rx,
      output data,
      output valid,
      output frame_err
   );

   modport slave (
      output rx,
      input  data,
      input  valid,
      input  frame_err
   );
endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both stages reset to RST_VAL.
module bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= {2{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe,
// one-cycle frame error strobe on a low stop bit.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_byte_if.master bus
);

   localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned CW   = $clog2(CPB);

   localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CPB - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   logic rx_s;

   bit_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx),
      .q   (rx_s)
   );

   uart_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          armed_q, armed_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      armed_d   = armed_q;
      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // after a framing error, wait for the line to idle high first
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d            = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
                  armed_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         armed_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         armed_q   <= armed_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at 16 clocks per bit.
// Stimulus queues expected strobes; a negedge monitor checks them.
module tb_uart_rx_byte;
   import uart_pkg::*;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];

   uart_rx_byte_if u_if ();

   uart_rx_byte #(
      .CLK_FREQ (1600),
      .BAUD     (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (u_if.valid && u_if.frame_err) begin
            check("valid_and_ferr", 1, 0);
         end
         if (u_if.valid || u_if.frame_err) begin
            if (q.size() == 0) begin
               check("unexpected_strobe", int'(u_if.frame_err), -1);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("strobe_kind", int'(u_if.frame_err), int'(e.is_err));
               check("strobe_cyc", cyc, e.cyc);
               if (!e.is_err) begin
                  check("data", int'(u_if.data), int'(e.data));
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at a negedge with the line high.
   task automatic send(
      input logic [7:0] b,
      input logic       stop_bit,
      input int         abort_bit
   );
      exp_t e;
      u_if.rx = 1'b0;
      if (abort_bit < 0) begin
         e.is_err = !stop_bit;
         e.data   = b;
         e.cyc    = cyc + 155;
         q.push_back(e);
      end
      idle(16);
      for (int k = 0; k < 8; k++) begin
         u_if.rx = b[k];
         if (k == abort_bit) begin
            idle(8);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            u_if.rx = 1'b1;
            check("rst_data", int'(u_if.data), 0);
            check("rst_valid", int'(u_if.valid), 0);
            check("rst_ferr", int'(u_if.frame_err), 0);
            return;
         end
         idle(16);
      end
      u_if.rx = stop_bit;
      idle(16);
      u_if.rx = 1'b1;
   endtask

   initial begin
      exp_t e;
      int   g;
      u_if.rx = 1'b1;
      idle(3);
      check("reset_data", int'(u_if.data), 0);
      check("reset_valid", int'(u_if.valid), 0);
      check("reset_ferr", int'(u_if.frame_err), 0);
      rst = 1'b1;
      idle(40);

      send(8'h35, 1'b1, -1);
      idle(40);

      send(8'h41, 1'b1, -1);
      send(8'h46, 1'b1, -1);
      idle(40);

      g = cyc;
      u_if.rx = 1'b0;
      idle(5);
      u_if.rx = 1'b1;
      idle(6);
      check("glitch_idle", int'(cyc == g + 11 && dut.state_q == IDLE), 1);
      idle(40);

      send(8'h33, 1'b0, -1);
      idle(40);
      check("ferr_keeps_data", int'(u_if.data), 8'h46);

      send(8'h39, 1'b1, 4);
      idle(200);
      send(8'h42, 1'b1, -1);
      idle(40);

      u_if.rx = 1'b0;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      e.cyc    = cyc + 155;
      q.push_back(e);
      idle(640);
      u_if.rx = 1'b1;
      idle(100);
      send(8'h30, 1'b1, -1);
      idle(60);

      check("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete (cyc %0d)", cyc);
      $fatal(1);
   end

endmodule
